// File: rtl/acorn_pkg.sv
// rtl/acorn_pkg.sv - shared phase encodings, mbit-select codes and step constants for the ACORN phase sequencer
package acorn_pkg;

    localparam int LEN_W       = 32;
    localparam int CNT_W       = 11;
    localparam int INIT_STEPS  = 1792;
    localparam int PAD_STEPS   = 256;
    localparam int PAD_HALF    = 128;
    localparam int FINAL_STEPS = 768;
    localparam int TAG_BITS    = 128;

    typedef enum logic [3:0] {
        PH_IDLE   = 4'd0,
        PH_LOAD   = 4'd1,
        PH_INIT   = 4'd2,
        PH_AD     = 4'd3,
        PH_AD_PAD = 4'd4,
        PH_PT     = 4'd5,
        PH_PT_PAD = 4'd6,
        PH_FINAL  = 4'd7,
        PH_DONE   = 4'd8
    } phase_e;

    typedef enum logic [1:0] {
        MSEL_ZERO = 2'd0,
        MSEL_INIT = 2'd1,
        MSEL_DATA = 2'd2,
        MSEL_ONE  = 2'd3
    } msel_e;

    function automatic logic [CNT_W-1:0] last_step(input int n);
        return CNT_W'(n - 1);
    endfunction

    localparam logic [CNT_W-1:0] INIT_LAST  = last_step(INIT_STEPS);
    localparam logic [CNT_W-1:0] PAD_LAST   = last_step(PAD_STEPS);
    localparam logic [CNT_W-1:0] FINAL_LAST = last_step(FINAL_STEPS);
    localparam logic [CNT_W-1:0] PAD_HALF_C = CNT_W'(PAD_HALF);
    // Tag bits are the trailing TAG_BITS steps of finalization.
    localparam logic [CNT_W-1:0] TAG_FIRST  = CNT_W'(FINAL_STEPS - TAG_BITS);

endpackage

// File: rtl/acorn_phase_ctrl_if.sv
// rtl/acorn_phase_ctrl_if.sv - command/data handshake and datapath control bundle of the phase sequencer
interface acorn_phase_ctrl_if;
    import acorn_pkg::*;

    logic             start_in;
    logic [LEN_W-1:0] ad_len_in;
    logic [LEN_W-1:0] pt_len_in;
    logic             din_valid_in;
    logic             din_ready_out;
    logic             step_en_out;
    logic             clr_state_out;
    logic             ca_out;
    logic             cb_out;
    logic [1:0]       msel_out;
    logic [10:0]      init_idx_out;
    logic [3:0]       phase_out;
    logic             tag_valid_out;
    logic             busy_out;
    logic             done_out;

    modport master (
        output start_in, ad_len_in, pt_len_in, din_valid_in,
        input  din_ready_out, step_en_out, clr_state_out, ca_out, cb_out, msel_out,
               init_idx_out, phase_out, tag_valid_out, busy_out, done_out
    );

    modport slave (
        input  start_in, ad_len_in, pt_len_in, din_valid_in,
        output din_ready_out, step_en_out, clr_state_out, ca_out, cb_out, msel_out,
               init_idx_out, phase_out, tag_valid_out, busy_out, done_out
    );

endinterface

// File: rtl/acorn_step_counter.sv
// rtl/acorn_step_counter.sv - 11-bit step counter with clear, enable and terminal-count compare
module acorn_step_counter
    import acorn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_in,
    input  logic             en_in,
    input  logic [CNT_W-1:0] term_in,
    output logic [CNT_W-1:0] count_out,
    output logic             tc_out
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over enable so a phase change always starts the new phase at step 0.
    always_comb begin
        count_d = count_q;
        if (clr_in) begin
            count_d = '0;
        end else if (en_in) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;
    assign tc_out    = (count_q == term_in);

endmodule

// File: rtl/acorn_phase_ctrl.sv
// rtl/acorn_phase_ctrl.sv - ACORN-128 phase sequencer: init, AD, AD pad, PT, PT pad and finalization control
module acorn_phase_ctrl
    import acorn_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    acorn_phase_ctrl_if.slave  bus
);

    phase_e           state_q, state_d;
    logic [LEN_W-1:0] ad_len_q, ad_len_d;
    logic [LEN_W-1:0] pt_len_q, pt_len_d;
    logic [LEN_W-1:0] dcnt_q, dcnt_d;
    logic [LEN_W-1:0] dcnt_inc;

    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] step_term;
    logic             step_tc;
    logic             step_clr;
    logic             step_cnt_en;
    logic             data_phase;
    logic             data_hs;

    logic             step_en;
    logic             clr_state;
    logic             ca;
    logic             cb;
    msel_e            msel;
    logic [CNT_W-1:0] init_idx;
    logic             tag_valid;
    logic             din_ready;
    logic             done;

    assign dcnt_inc = dcnt_q + LEN_W'(1);

    always_comb begin
        state_d    = state_q;
        ad_len_d   = ad_len_q;
        pt_len_d   = pt_len_q;
        step_en    = 1'b0;
        clr_state  = 1'b0;
        ca         = 1'b0;
        cb         = 1'b0;
        msel       = MSEL_ZERO;
        init_idx   = '0;
        tag_valid  = 1'b0;
        din_ready  = 1'b0;
        done       = 1'b0;
        step_term  = '0;
        data_phase = 1'b0;
        data_hs    = 1'b0;

        unique case (state_q)
            PH_IDLE: begin
                if (bus.start_in) begin
                    state_d  = PH_LOAD;
                    ad_len_d = bus.ad_len_in;
                    pt_len_d = bus.pt_len_in;
                end
            end
            PH_LOAD: begin
                clr_state = 1'b1;
                state_d   = PH_INIT;
            end
            PH_INIT: begin
                step_en   = 1'b1;
                ca        = 1'b1;
                cb        = 1'b1;
                msel      = MSEL_INIT;
                init_idx  = step_cnt;
                step_term = INIT_LAST;
                if (step_tc) begin
                    state_d = (ad_len_q != '0) ? PH_AD : PH_AD_PAD;
                end
            end
            PH_AD: begin
                ca         = 1'b1;
                cb         = 1'b1;
                msel       = MSEL_DATA;
                din_ready  = 1'b1;
                data_phase = 1'b1;
                data_hs    = bus.din_valid_in;
                step_en    = bus.din_valid_in;
                if (data_hs && (dcnt_inc == ad_len_q)) begin
                    state_d = PH_AD_PAD;
                end
            end
            PH_AD_PAD: begin
                step_en   = 1'b1;
                cb        = 1'b1;
                ca        = (step_cnt < PAD_HALF_C);
                msel      = (step_cnt == '0) ? MSEL_ONE : MSEL_ZERO;
                step_term = PAD_LAST;
                if (step_tc) begin
                    state_d = (pt_len_q != '0) ? PH_PT : PH_PT_PAD;
                end
            end
            PH_PT: begin
                ca         = 1'b1;
                msel       = MSEL_DATA;
                din_ready  = 1'b1;
                data_phase = 1'b1;
                data_hs    = bus.din_valid_in;
                step_en    = bus.din_valid_in;
                if (data_hs && (dcnt_inc == pt_len_q)) begin
                    state_d = PH_PT_PAD;
                end
            end
            PH_PT_PAD: begin
                step_en   = 1'b1;
                ca        = (step_cnt < PAD_HALF_C);
                msel      = (step_cnt == '0) ? MSEL_ONE : MSEL_ZERO;
                step_term = PAD_LAST;
                if (step_tc) begin
                    state_d = PH_FINAL;
                end
            end
            PH_FINAL: begin
                step_en   = 1'b1;
                ca        = 1'b1;
                cb        = 1'b1;
                tag_valid = (step_cnt >= TAG_FIRST);
                step_term = FINAL_LAST;
                if (step_tc) begin
                    state_d = PH_DONE;
                end
            end
            PH_DONE: begin
                done    = 1'b1;
                state_d = PH_IDLE;
            end
            default: begin
                state_d = PH_IDLE;
            end
        endcase
    end

    // The step counter only tracks fixed-length phases; data phases are measured by dcnt.
    assign step_clr    = (state_d != state_q);
    assign step_cnt_en = step_en && !data_phase;

    always_comb begin
        dcnt_d = dcnt_q;
        if (state_d != state_q) begin
            dcnt_d = '0;
        end else if (data_hs) begin
            dcnt_d = dcnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= PH_IDLE;
            ad_len_q <= '0;
            pt_len_q <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            ad_len_q <= ad_len_d;
            pt_len_q <= pt_len_d;
            dcnt_q   <= dcnt_d;
        end
    end

    acorn_step_counter u_step_counter (
        .clk       (clk),
        .rst       (rst),
        .clr_in    (step_clr),
        .en_in     (step_cnt_en),
        .term_in   (step_term),
        .count_out (step_cnt),
        .tc_out    (step_tc)
    );

    assign bus.din_ready_out = din_ready;
    assign bus.step_en_out   = step_en;
    assign bus.clr_state_out = clr_state;
    assign bus.ca_out        = ca;
    assign bus.cb_out        = cb;
    assign bus.msel_out      = msel;
    assign bus.init_idx_out  = init_idx;
    assign bus.phase_out     = state_q;
    assign bus.tag_valid_out = tag_valid;
    assign bus.busy_out      = (state_q != PH_IDLE);
    assign bus.done_out      = done;

endmodule

// File: tb/tb_acorn_phase_ctrl.sv
// tb/tb_acorn_phase_ctrl.sv - directed self-checking bench for acorn_phase_ctrl
module tb_acorn_phase_ctrl;

    localparam int P_IDLE = 0, P_LOAD = 1, P_INIT = 2, P_AD = 3, P_AD_PAD = 4;
    localparam int P_PT = 5, P_PT_PAD = 6, P_FINAL = 7, P_DONE = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acorn_phase_ctrl_if bus();

    acorn_phase_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [24:0] outs;
    assign outs = {bus.din_ready_out, bus.step_en_out, bus.clr_state_out, bus.ca_out, bus.cb_out,
                   bus.msel_out, bus.init_idx_out, bus.phase_out, bus.tag_valid_out,
                   bus.busy_out, bus.done_out};

    int checks   = 0;
    int failures = 0;

    int n_step, n_clr, clr_cyc, n_done, done_cyc, n_tag, first_tag;
    int n_init, init_err, n_ad, n_ad_cyc, ad_err, n_pt, pt_err, n_pad, pad_err, fin_err, gen_err;
    bit finished;

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Runs one operation from start to the done pulse, recording per-phase statistics.
    task automatic run_op(input int ad, input int pt, input int vmode, input int pulse, input int max_cyc);
        int seg;
        int ph;
        int prev_ph;
        n_step = 0; n_clr = 0; clr_cyc = -1; n_done = 0; done_cyc = -1; n_tag = 0; first_tag = -1;
        n_init = 0; init_err = 0; n_ad = 0; n_ad_cyc = 0; ad_err = 0; n_pt = 0; pt_err = 0;
        n_pad = 0; pad_err = 0; fin_err = 0; gen_err = 0; finished = 0;
        bus.ad_len_in    = ad;
        bus.pt_len_in    = pt;
        bus.start_in     = 1'b1;
        bus.din_valid_in = 1'b0;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        prev_ph = -1;
        seg = 0;
        for (int c = 1; c <= max_cyc && !finished; c++) begin
            bus.din_valid_in = (vmode == 0) ? 1'b1 : ((c % 3) == 0);
            bus.start_in     = (pulse != 0) && (c == 500 || c == 2500);
            #1;
            ph = int'(bus.phase_out);
            if (ph != prev_ph) seg = 0;
            if (bus.step_en_out) n_step++;
            if (bus.clr_state_out) begin n_clr++; clr_cyc = c; end
            if (bus.tag_valid_out) begin n_tag++; if (first_tag < 0) first_tag = c; end
            if (bus.clr_state_out != (ph == P_LOAD)) gen_err++;
            if (bus.din_ready_out != (ph == P_AD || ph == P_PT)) gen_err++;
            if (bus.busy_out != (ph != P_IDLE)) gen_err++;
            if (bus.done_out != (ph == P_DONE)) gen_err++;
            if (ph != P_INIT && bus.init_idx_out != 0) gen_err++;
            if ((ph == P_LOAD || ph == P_DONE) && (bus.step_en_out || bus.ca_out || bus.cb_out || bus.msel_out != 0)) gen_err++;
            case (ph)
                P_INIT: begin
                    n_init++;
                    if (!bus.step_en_out || !bus.ca_out || !bus.cb_out || bus.msel_out != 1 ||
                        bus.init_idx_out != seg || bus.tag_valid_out) init_err++;
                end
                P_AD: begin
                    n_ad_cyc++;
                    if (bus.step_en_out) n_ad++;
                    if (bus.step_en_out !== bus.din_valid_in || !bus.ca_out || !bus.cb_out ||
                        bus.msel_out != 2 || bus.tag_valid_out) ad_err++;
                end
                P_PT: begin
                    if (bus.step_en_out) n_pt++;
                    if (bus.step_en_out !== bus.din_valid_in || !bus.ca_out || bus.cb_out ||
                        bus.msel_out != 2 || bus.tag_valid_out) pt_err++;
                end
                P_AD_PAD, P_PT_PAD: begin
                    n_pad++;
                    if (!bus.step_en_out || bus.ca_out != (seg < 128) || bus.cb_out != (ph == P_AD_PAD) ||
                        bus.msel_out != ((seg == 0) ? 3 : 0) || bus.tag_valid_out) pad_err++;
                end
                P_FINAL: begin
                    if (!bus.step_en_out || !bus.ca_out || !bus.cb_out || bus.msel_out != 0 ||
                        bus.tag_valid_out != (seg >= 640)) fin_err++;
                end
                default: ;
            endcase
            if (bus.done_out) begin n_done++; done_cyc = c; finished = 1; end
            seg++;
            prev_ph = ph;
            @(posedge clk); #1;
        end
        bus.start_in     = 1'b0;
        bus.din_valid_in = 1'b0;
    endtask

    initial begin
        int bad;
        bus.start_in     = 1'b0;
        bus.ad_len_in    = '0;
        bus.pt_len_in    = '0;
        bus.din_valid_in = 1'b0;

        // Test 1: reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", int'(outs), 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (outs != 0) bad++;
        end
        chk("idle_nonzero_cycles", bad, 0);
        chk("idle_phase", int'(bus.phase_out), P_IDLE);
        @(posedge clk); #1;

        // Test 2: empty AD and PT
        run_op(0, 0, 0, 0, 4000);
        chk("t2_finished", int'(finished), 1);
        chk("t2_clr_cycle", clr_cyc, 1);
        chk("t2_clr_count", n_clr, 1);
        chk("t2_steps", n_step, 3072);
        chk("t2_done_cycle", done_cyc, 3074);
        chk("t2_done_count", n_done, 1);
        chk("t2_tag_count", n_tag, 128);
        chk("t2_first_tag", first_tag, 2946);
        chk("t2_init_steps", n_init, 1792);
        chk("t2_init_err", init_err, 0);
        chk("t2_pad_steps", n_pad, 512);
        chk("t2_pad_err", pad_err, 0);
        chk("t2_final_err", fin_err, 0);
        chk("t2_gen_err", gen_err, 0);
        #1;
        chk("t2_idle_after", int'(outs), 0);

        // Test 5: start pulses during INIT and FINAL are ignored
        run_op(0, 0, 0, 1, 4000);
        chk("t5_finished", int'(finished), 1);
        chk("t5_done_count", n_done, 1);
        chk("t5_done_cycle", done_cyc, 3074);
        chk("t5_clr_count", n_clr, 1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (outs != 0) bad++;
            @(posedge clk); #1;
        end
        chk("t5_idle_after", bad, 0);

        // Test 3: ad=8, pt=16 with data always valid
        run_op(8, 16, 0, 0, 4000);
        chk("t3_finished", int'(finished), 1);
        chk("t3_ad_steps", n_ad, 8);
        chk("t3_ad_err", ad_err, 0);
        chk("t3_pt_steps", n_pt, 16);
        chk("t3_pt_err", pt_err, 0);
        chk("t3_pad_err", pad_err, 0);
        chk("t3_steps", n_step, 3096);
        chk("t3_done_cycle", done_cyc, 3098);
        chk("t3_gen_err", gen_err, 0);

        // Test 4: ad=4 with din_valid pattern 1,0,0,1,...
        @(posedge clk); #1;
        run_op(4, 0, 1, 0, 4000);
        chk("t4_finished", int'(finished), 1);
        chk("t4_ad_steps", n_ad, 4);
        chk("t4_ad_cycles", n_ad_cyc, 10);
        chk("t4_ad_err", ad_err, 0);
        chk("t4_pt_steps", n_pt, 0);
        chk("t4_done_cycle", done_cyc, 3084);
        chk("t4_gen_err", gen_err, 0);

        // Test 6: reset at INIT step 1000, then restart
        @(posedge clk); #1;
        bus.ad_len_in = 32'd3;
        bus.pt_len_in = 32'd5;
        bus.start_in  = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        repeat (1001) @(posedge clk);
        #2;
        chk("t6_init_idx_pre", int'(bus.init_idx_out), 1000);
        chk("t6_phase_pre", int'(bus.phase_out), P_INIT);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("t6_outs_after_rst", int'(outs), 0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            if (outs != 0) bad++;
        end
        chk("t6_quiet_after_rst", bad, 0);
        bus.start_in = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        #1;
        chk("t6_restart_load", int'(bus.phase_out), P_LOAD);
        @(posedge clk); #2;
        chk("t6_restart_idx0", int'(bus.init_idx_out), 0);
        chk("t6_restart_phase", int'(bus.phase_out), P_INIT);
        @(posedge clk); #2;
        chk("t6_restart_idx1", int'(bus.init_idx_out), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
